cpuf_core: RTL and testbench

- Parametrised accumulator CPU core; next generation of the fixed 8-bit/4-bit-address fetch-decode-execute machine.
- Holds PC, IR, A, B, accumulator, flags and a single sequencing FSM.
- Talks to an external unified instruction/data memory over a req/ack handshake, so memory may insert wait states.
- Adds store, conditional jumps, zero/carry flags, halt/resume and illegal-opcode reporting.

---
 rtl/cpuf_pkg.sv | 31 +++
 rtl/cpuf_alu.sv | 49 ++++
 rtl/cpuf_core.sv | 146 ++++++++++++++
 tb/tb_cpuf_core.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpuf_pkg.sv
// rtl/cpuf_pkg.sv - opcode encodings, FSM state and ALU select types shared by the cpuf core.
package cpuf_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_STA = 4'h3;
  localparam logic [OP_W-1:0] OP_LDB = 4'h4;
  localparam logic [OP_W-1:0] OP_LDA = 4'h8;
  localparam logic [OP_W-1:0] OP_JMP = 4'h9;
  localparam logic [OP_W-1:0] OP_JZ  = 4'hB;
  localparam logic [OP_W-1:0] OP_MUL = 4'hC;
  localparam logic [OP_W-1:0] OP_JC  = 4'hD;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEM,
    ST_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_MUL
  } alu_op_t;

endpackage

// File: rtl/cpuf_alu.sv
// rtl/cpuf_alu.sv - combinational add/sub (and multiply when CPUF_MUL_EN is defined) with carry and zero.
module cpuf_alu
  import cpuf_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
`ifdef CPUF_MUL_EN
  logic [2*DATA_W-1:0] prod;
`endif

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    // The extra top bit of an unsigned difference is the borrow.
    diff = {1'b0, a} - {1'b0, b};
`ifdef CPUF_MUL_EN
    prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif
    result = sum[DATA_W-1:0];
    carry  = sum[DATA_W];
    case (op)
      ALU_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
      end
`ifdef CPUF_MUL_EN
      ALU_MUL: begin
        result = prod[DATA_W-1:0];
        carry  = |prod[2*DATA_W-1:DATA_W];
      end
`endif
      default: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
    endcase
    zero = ~|result;
  end

endmodule

// File: rtl/cpuf_core.sv
// rtl/cpuf_core.sv - accumulator CPU core with req/ack memory port; CPUF_MUL_EN enables opcode 1100 as MUL.
module cpuf_core
  import cpuf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              resume,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] acc_o,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic              zf,
  output logic              cf
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] acc;

  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] operand;
  alu_op_t           alu_op;
  logic              is_arith;
  logic              is_mem;
  logic              is_illegal;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;
  logic              handshake;

  assign opcode  = ir[DATA_W-1 -: OP_W];
  assign operand = ir[ADDR_W-1:0];

  always_comb begin
    alu_op     = ALU_ADD;
    is_arith   = 1'b0;
    is_mem     = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_NOP, OP_JMP, OP_JZ, OP_JC, OP_HLT: ;
      OP_ADD: is_arith = 1'b1;
      OP_SUB: begin
        is_arith = 1'b1;
        alu_op   = ALU_SUB;
      end
      OP_STA, OP_LDA, OP_LDB: is_mem = 1'b1;
`ifdef CPUF_MUL_EN
      OP_MUL: begin
        is_arith = 1'b1;
        alu_op   = ALU_MUL;
      end
`endif
      default: is_illegal = 1'b1;
    endcase
  end

  cpuf_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (alu_op),
    .a      (a),
    .b      (b),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // Request is gated by reset so an in-flight access drops in the reset cycle itself.
  assign mem_req   = ((state == ST_FETCH) || (state == ST_MEM)) && !reset;
  assign mem_we    = (state == ST_MEM) && (opcode == OP_STA) && !reset;
  assign mem_addr  = (state == ST_FETCH) ? pc : operand;
  assign mem_wdata = acc;
  assign handshake = mem_req && mem_ack;

  assign halted = (state == ST_HALT);
  assign pc_o   = pc;
  assign acc_o  = acc;
  assign a_o    = a;
  assign b_o    = b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_FETCH;
      pc      <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      acc     <= '0;
      zf      <= 1'b0;
      cf      <= 1'b0;
      illegal <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (handshake) begin
            ir    <= mem_rdata;
            pc    <= pc + ADDR_W'(1);
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          state <= ST_FETCH;
          if (is_arith) begin
            acc <= alu_result;
            cf  <= alu_carry;
            zf  <= alu_zero;
          end
          if (is_illegal) illegal <= 1'b1;
          if (is_mem) state <= ST_MEM;
          case (opcode)
            OP_JMP: pc <= operand;
            OP_JZ:  if (zf) pc <= operand;
            OP_JC:  if (cf) pc <= operand;
            OP_HLT: state <= ST_HALT;
            default: ;
          endcase
        end
        ST_MEM: begin
          if (handshake) begin
            if (opcode == OP_LDA) a <= mem_rdata;
            if (opcode == OP_LDB) b <= mem_rdata;
            state <= ST_FETCH;
          end
        end
        ST_HALT: begin
          if (resume) state <= ST_FETCH;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpuf_core.sv
// tb/tb_cpuf_core.sv - directed programs against an instruction-level model with a wait-state memory.
module tb_cpuf_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_ack = 1'b0;
  logic       resume = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_req, mem_we, halted, illegal, zf, cf;
  logic [3:0] mem_addr, pc_o;
  logic [7:0] mem_wdata, acc_o, a_o, b_o;

  cpuf_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .resume(resume),
    .halted(halted), .illegal(illegal), .pc_o(pc_o), .acc_o(acc_o), .a_o(a_o), .b_o(b_o),
    .zf(zf), .cf(cf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] tb_mem [16];
  logic [7:0] m_mem [16];
  int ack_delay = 0;
  bit spurious = 1'b0;
  int wcnt = 0;

  int m_pc, m_a, m_b, m_acc, m_phase, m_op, m_opr;
  bit m_zf, m_cf;
  int exp_ill, ill_seen;
  bit prev_ill;
  bit waiting_prev;
  logic [3:0] prev_addr;
  logic prev_we;
  logic [7:0] prev_wdata;
  int cyc = 0;
  int fetch_start, waits, prev_base;
  bit have_prev;

  // Architectural effect of one fetched instruction word.
  task automatic model_exec(input logic [7:0] w);
    int op, opr, r;
    op = int'(w[7:4]);
    opr = int'(w[3:0]);
    m_pc = (m_pc + 1) % 16;
    prev_base = 2;
    have_prev = 1'b1;
    case (op)
      0: ;
      1: begin
        r = m_a - m_b;
        m_cf = (m_a < m_b);
        m_acc = (r + 256) % 256;
        m_zf = (m_acc == 0);
      end
      2: begin
        r = m_a + m_b;
        m_cf = (r >= 256);
        m_acc = r % 256;
        m_zf = (m_acc == 0);
      end
      3, 4, 8: begin
        m_phase = 1;
        m_op = op;
        m_opr = opr;
        prev_base = 3;
      end
      9: m_pc = opr;
      11: if (m_zf) m_pc = opr;
      13: if (m_cf) m_pc = opr;
      15: have_prev = 1'b0;
`ifdef CPUF_MUL_EN
      12: begin
        r = m_a * m_b;
        m_cf = (r >= 256);
        m_acc = r % 256;
        m_zf = (m_acc == 0);
      end
`endif
      default: exp_ill++;
    endcase
  endtask

  // Memory responder followed by the per-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (mem_req) begin
      if (wcnt >= ack_delay) begin
        mem_ack = 1'b1;
        mem_rdata = tb_mem[mem_addr];
        if (mem_we) tb_mem[mem_addr] = mem_wdata;
        wcnt = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = spurious;
      wcnt = 0;
    end
    cyc++;
    if (reset) begin
      chk("req_in_reset", mem_req, 0);
      m_pc = 0; m_a = 0; m_b = 0; m_acc = 0; m_zf = 0; m_cf = 0; m_phase = 0;
      exp_ill = 0; ill_seen = 0; prev_ill = 0; waiting_prev = 0; have_prev = 0; waits = 0;
    end else begin
      if (illegal) begin
        ill_seen++;
        chk("illegal_pulse_width", prev_ill, 0);
      end
      prev_ill = illegal;
      if (halted) chk("req_while_halted", mem_req, 0);
      if (waiting_prev) begin
        chk("req_held", mem_req, 1);
        chk("addr_held", mem_addr, prev_addr);
        chk("we_held", mem_we, prev_we);
        if (prev_we) chk("wdata_held", mem_wdata, prev_wdata);
      end
      if (mem_req && !waiting_prev && m_phase == 0) begin
        if (have_prev) chk("latency", cyc - fetch_start, prev_base + waits);
        fetch_start = cyc;
        waits = 0;
      end
      if (mem_req && !mem_ack) waits++;
      if (mem_req && mem_ack) begin
        if (m_phase == 0) begin
          chk("fetch_addr", mem_addr, m_pc);
          chk("fetch_we", mem_we, 0);
          chk("pc", pc_o, m_pc);
          chk("acc", acc_o, m_acc);
          chk("a", a_o, m_a);
          chk("b", b_o, m_b);
          chk("zf", zf, m_zf);
          chk("cf", cf, m_cf);
          model_exec(m_mem[m_pc]);
        end else begin
          chk("data_addr", mem_addr, m_opr);
          chk("data_we", mem_we, m_op == 3);
          if (m_op == 3) begin
            chk("sta_wdata", mem_wdata, m_acc);
            m_mem[m_opr] = 8'(m_acc);
          end else if (m_op == 8) m_a = int'(m_mem[m_opr]);
          else m_b = int'(m_mem[m_opr]);
          m_phase = 0;
        end
      end
      waiting_prev = mem_req && !mem_ack;
      prev_addr = mem_addr;
      prev_we = mem_we;
      prev_wdata = mem_wdata;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      tb_mem[i] = 8'h00;
      m_mem[i] = 8'h00;
    end
  endtask

  task automatic put(input int ad, input logic [7:0] v);
    tb_mem[ad] = v;
    m_mem[ad] = v;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int i;
    i = 0;
    while (!halted && i < 1000) begin
      @(posedge clk); #2;
      i++;
    end
    chk({name, "_halted"}, halted, 1);
  endtask

  task automatic load_prog1();
    clear_mem();
    put(0, 8'h86); put(1, 8'h45); put(2, 8'h20); put(3, 8'h3F);
    put(4, 8'hF0); put(5, 8'h0C); put(6, 8'h0E);
  endtask

  task automatic run_arith(input logic [7:0] opw, input logic [7:0] br, input logic [7:0] av,
                           input logic [7:0] bv, input int tgt);
    clear_mem();
    put(0, 8'h8C); put(1, 8'h4D); put(2, opw); put(3, br); put(4, 8'hF0);
    put(tgt, 8'hF0); put(12, av); put(13, bv);
    do_reset();
    wait_halt("arith");
  endtask

  initial begin
    bit found;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_pc", pc_o, 0); chk("rst_acc", acc_o, 0); chk("rst_a", a_o, 0);
    chk("rst_b", b_o, 0); chk("rst_zf", zf, 0); chk("rst_cf", cf, 0);
    chk("rst_halted", halted, 0); chk("rst_illegal", illegal, 0); chk("rst_req", mem_req, 0);

    load_prog1();
    ack_delay = 0; spurious = 0;
    do_reset();
    wait_halt("t1");
    chk("t1_mem15", tb_mem[15], 8'h1A); chk("t1_pc", pc_o, 5); chk("t1_zf", zf, 0);
    chk("t1_cf", cf, 0); chk("t1_a", a_o, 8'h0E); chk("t1_b", b_o, 8'h0C);
    chk("t1_acc", acc_o, 8'h1A); chk("t1_illegal", ill_seen, 0);

    run_arith(8'h20, 8'hD9, 8'hF0, 8'h20, 9);
    chk("t2_acc", acc_o, 8'h10); chk("t2_cf", cf, 1); chk("t2_pc", pc_o, 4'hA);
    run_arith(8'h20, 8'hD9, 8'h10, 8'h20, 9);
    chk("t2b_acc", acc_o, 8'h30); chk("t2b_cf", cf, 0); chk("t2b_pc", pc_o, 5);

    run_arith(8'h10, 8'hB7, 8'h05, 8'h05, 7);
    chk("t3_acc", acc_o, 8'h00); chk("t3_zf", zf, 1); chk("t3_cf", cf, 0); chk("t3_pc", pc_o, 8);
    run_arith(8'h10, 8'hB7, 8'h03, 8'h05, 7);
    chk("t3b_acc", acc_o, 8'hFE); chk("t3b_cf", cf, 1); chk("t3b_zf", zf, 0); chk("t3b_pc", pc_o, 5);

    load_prog1();
    ack_delay = 3; spurious = 1;
    do_reset();
    wait_halt("t4");
    chk("t4_mem15", tb_mem[15], 8'h1A); chk("t4_pc", pc_o, 5);
    chk("t4_a", a_o, 8'h0E); chk("t4_b", b_o, 8'h0C);
    ack_delay = 0; spurious = 0;

    clear_mem();
    put(0, 8'h8C); put(1, 8'h4D); put(2, 8'h20); put(3, 8'h30); put(4, 8'h9F);
    put(12, 8'hF0); put(13, 8'h00); put(15, 8'h70);
    do_reset();
    wait_halt("t5a");
    chk("t5a_illegal_count", ill_seen, 1); chk("t5a_mem0", tb_mem[0], 8'hF0); chk("t5a_pc", pc_o, 1);

    clear_mem();
    put(2, 8'hF0); put(3, 8'h8C); put(4, 8'hF0); put(12, 8'h5A);
    do_reset();
    wait_halt("t5b");
    chk("t5b_pc_halt", pc_o, 3);
    spurious = 1;
    repeat (10) @(posedge clk);
    #2 chk("t5b_still_halted", halted, 1);
    resume = 1'b1;
    @(posedge clk); #2 resume = 1'b0;
    spurious = 0;
    chk("t5b_left_halt", halted, 0);
    wait_halt("t5b_2");
    chk("t5b_pc", pc_o, 5); chk("t5b_a", a_o, 8'h5A);

    load_prog1();
    ack_delay = 5;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk); #2;
      if (mem_req && mem_we) found = 1'b1;
    end
    chk("t6_sta_reached", found, 1);
    reset = 1'b1;
    #1 chk("t6_req_in_reset", mem_req, 0);
    @(posedge clk); #2;
    chk("t6_pc", pc_o, 0); chk("t6_acc", acc_o, 0); chk("t6_a", a_o, 0); chk("t6_b", b_o, 0);
    chk("t6_zf", zf, 0); chk("t6_cf", cf, 0); chk("t6_mem15", tb_mem[15], 0);
    reset = 1'b0;
    #1 chk("t6_req_after", mem_req, 1);
    chk("t6_addr_after", mem_addr, 0); chk("t6_we_after", mem_we, 0);
    ack_delay = 0;
    wait_halt("t6");
    chk("t6_mem15_rerun", tb_mem[15], 8'h1A);

    clear_mem();
    put(0, 8'h8C); put(1, 8'h4D); put(2, 8'hC0); put(3, 8'hF0); put(12, 8'h10); put(13, 8'h10);
    do_reset();
    wait_halt("mul");
`ifdef CPUF_MUL_EN
    chk("mul_acc", acc_o, 8'h00); chk("mul_cf", cf, 1); chk("mul_zf", zf, 1);
    chk("mul_illegal", ill_seen, 0);
`else
    chk("mul_acc", acc_o, 8'h00); chk("mul_cf", cf, 0); chk("mul_zf", zf, 0);
    chk("mul_illegal", ill_seen, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1);
  end

endmodule
